muldiv_sequencer: RTL

Multi-cycle controller and datapath for the RV32M multiply/divide instructions in the execute stage. It sits beside the single-cycle ALU. It accepts an M-extension operation selected by funct3, runs a one-bit-per-cycle shift-add multiply or restoring divide, and holds the pipeline stall until the result is ready. R-type instructions with funct7 = 0000001 are routed here instead of the ALU.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_iter_dp.sv | 67 ++++++
 rtl/muldiv_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 op codes,
// FSM state encoding and width defaults.
package muldiv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN_DEFAULT-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    // Ops whose rs1 operand is interpreted as two's complement.
    function automatic logic srca_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic srcb_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// One-bit-per-cycle iteration datapath: 2*XLEN accumulator {hi, lo} and a single
// XLEN+1-bit adder shared between shift-add multiply and restoring divide.
module muldiv_iter_dp
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   init_lo,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc
);

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN:0]   add_a, add_b, sum;
    logic            cin;

    always_comb begin
        if (is_div) begin
            // Trial subtract of the divisor from the left-shifted remainder.
            add_a = {hi_q, lo_q[XLEN-1]};
            add_b = ~{1'b0, operand};
            cin   = 1'b1;
        end else begin
            add_a = {1'b0, hi_q};
            add_b = lo_q[0] ? {1'b0, operand} : '0;
            cin   = 1'b0;
        end
        sum = add_a + add_b + {{XLEN{1'b0}}, cin};
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (load) begin
            hi_d = '0;
            lo_d = init_lo;
        end else if (step) begin
            if (is_div) begin
                // Sign bit of the difference set means the trial went negative: restore.
                hi_d = sum[XLEN] ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : sum[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], ~sum[XLEN]};
            end else begin
                hi_d = sum[XLEN:1];
                lo_d = {sum[0], lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign acc = {hi_q, lo_q};

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide controller with sign handling and fast paths.
// Define MULDIV_ZERO_EARLY_OUT_EN to let MUL* ops with a zero operand skip iteration.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, done_q;

    logic              a_neg, b_neg, in_is_div;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div0, ovf, mul_zero, fast;
    logic [XLEN-1:0]   fast_result;
    logic              dp_load, dp_step;
    logic [2*XLEN-1:0] acc, full, fixed;
    logic [XLEN-1:0]   fix_result;

    assign in_is_div = funct3[2];
    assign a_neg     = srca_is_signed(funct3) & srcA[XLEN-1];
    assign b_neg     = srcb_is_signed(funct3) & srcB[XLEN-1];
    assign mag_a     = a_neg ? -srcA : srcA;
    assign mag_b     = b_neg ? -srcB : srcB;

    assign div0 = in_is_div & (srcB == '0);
    assign ovf  = in_is_div & ~funct3[0] & (srcA == {1'b1, {(XLEN-1){1'b0}}}) & (srcB == '1);

`ifdef MULDIV_ZERO_EARLY_OUT_EN
    assign mul_zero = ~in_is_div & ((srcA == '0) | (srcB == '0));
`else
    assign mul_zero = 1'b0;
`endif

    assign fast = div0 | ovf | mul_zero;

    always_comb begin
        fast_result = '0;
        if (div0) begin
            fast_result = funct3[1] ? srcA : XLEN'(DIV0_QUOTIENT);
        end else if (ovf) begin
            fast_result = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    muldiv_iter_dp #(
        .XLEN (XLEN)
    ) u_iter_dp (
        .clk     (clk),
        .reset   (reset),
        .load    (dp_load),
        .step    (dp_step),
        .is_div  (op_q[2]),
        .init_lo (in_is_div ? mag_a : mag_b),
        .operand (opnd_q),
        .acc     (acc)
    );

    // Division picks quotient (lo) or remainder (hi) first, so one 2*XLEN negate serves all ops.
    always_comb begin
        if (op_q[2]) begin
            full = {{XLEN{1'b0}}, (op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0])};
        end else begin
            full = acc;
        end
        fixed      = neg_q ? -full : full;
        fix_result = (!op_q[2] && op_q[1:0] != 2'b00) ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        dp_load  = 1'b0;
        dp_step  = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d    = funct3;
                        opnd_d  = in_is_div ? mag_b : mag_a;
                        neg_d   = (in_is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                        count_d = CW'(XLEN - 1);
                        dp_load = 1'b1;
                        if (fast) begin
                            result_d = fast_result;
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    dp_step = 1'b1;
                    if (count_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                S_FIX: begin
                    result_d = fix_result;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
